instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 The block SHALL have parameter STEP_CYCLES, default 4, meaning clocks per micro-step; legal values are 3 to 15.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous reset, active low.
REQ-005 run  in  1  start/resume request; sampled only in HALTED.
REQ-006 inst  in  8  instruction register contents (Inst latch output).
REQ-007 flag_z, flag_c, flag_s  in  1 each  ALU zero, carry and sign flags.
REQ-008 exec_done  in  1  execute unit completion; sampled only in EXEC.
REQ-009 sel_pc, sel_inc, sel_j  out  1 each  address-bus source selects.
REQ-010 mem_read  out  1  memory drives the data bus.
REQ-011 ld_inst, ld_inc, ld_pc, ld_j1, ld_j2  out  1 each  register load strobes.
REQ-012 exec_start  out  1  one-cycle pulse handing a non-GOTO, non-HALT opcode to the execute unit.
REQ-013 halted  out  1  high while in HALTED.

Function
REQ-014 States SHALL be HALTED, FETCH_I, INC_I, DECODE, EXEC, FETCH_J1, INC_J1, FETCH_J2, INC_J2 and JUMP.
REQ-015 Every FETCH_*/INC_*/JUMP-taken step SHALL last exactly STEP_CYCLES clocks, counted by step counter cnt = 0..STEP_CYCLES-1.
REQ-016 Select strobes and mem_read SHALL be held for all cycles of their step; ld_* strobes SHALL be high only at cnt == STEP_CYCLES-2.
REQ-017 Strobes per step SHALL be:
- FETCH_I: sel_pc, mem_read; loads ld_inst and ld_inc.
- INC_I: sel_inc; load ld_pc.
- FETCH_J1: sel_pc, mem_read; loads ld_j1 and ld_inc.
- INC_J1: sel_inc; load ld_pc.
- FETCH_J2: sel_pc, mem_read; loads ld_j2 and ld_inc.
- INC_J2: sel_inc; load ld_pc.
- JUMP taken: sel_j; load ld_pc.
REQ-018 At most one of sel_pc, sel_inc and sel_j SHALL be high in any cycle.
REQ-019 DECODE SHALL last one cycle and branch on inst:
- 8'hAE -> HALTED.
- inst[7:6] == 2'b11 -> FETCH_J1.
- else -> EXEC, with exec_start high during the DECODE cycle.
REQ-020 EXEC SHALL emit no strobes and SHALL go to FETCH_I on the cycle after exec_done is sampled high; exec_done is ignored in every other state.
REQ-021 The GOTO condition SHALL use inst[4:1] = {s, c, z, nz} and SHALL be taken if those bits are 0000, or if (s&flag_s)|(c&flag_c)|(z&flag_z)|(nz&~flag_z).
REQ-022 Flags SHALL be sampled on the first JUMP cycle; a taken jump lasts STEP_CYCLES clocks, a not-taken jump lasts one cycle with no strobes; both then go to FETCH_I.
REQ-023 inst[5] and inst[0] SHALL be ignored for GOTO.
REQ-024 In HALTED, run high SHALL move to FETCH_I on the next edge; run is ignored in every other state.
REQ-025 In the last cycle of INC_I, cnt SHALL wrap to 0 as the state moves to DECODE.

Reset
REQ-026 While reset_n is low, the state SHALL be HALTED, cnt SHALL be 0, all strobes and exec_start SHALL be 0, and halted SHALL be 1, immediately and without waiting for clk.
REQ-027 Reset asserted mid-step SHALL abort the step with no further load strobe; the next run starts at FETCH_I with cnt = 0.

Structure
REQ-028 The state enum, OP_HALT = 8'hAE and GOTO_PREFIX = 2'b11 SHALL live in shared package seq_pkg.
REQ-029 Step timing SHALL be a sub-module, step_timer, with inputs clk, reset_n and restart, and outputs cnt, load_win and step_last.

Verification (STEP_CYCLES = 4)
REQ-030 Reset, then run pulse with inst = 8'h10 and exec_done 2 cycles after exec_start -> sel_pc and mem_read for 4 cycles, ld_inst and ld_inc at cycle 3, sel_inc for 4 cycles with ld_pc at cycle 7, exec_start at cycle 9, FETCH_I again at cycle 12.
REQ-031 inst = 8'hC0 (unconditional GOTO) -> ld_j1 then ld_j2 each 8 clocks apart, then sel_j for 4 cycles with one ld_pc.
REQ-032 inst = 8'hC4 with flag_z = 0 -> JUMP lasts 1 cycle, sel_j never high; same inst with flag_z = 1 -> jump taken.
REQ-033 inst = 8'hAE -> halted high after DECODE; exec_done pulses are ignored; run then restarts at FETCH_I.
REQ-034 reset_n low at cnt = 1 of INC_J1 -> all strobes drop in the same cycle, no ld_pc is seen, and halted = 1.
REQ-035 Assertion on every cycle: sel strobes one-hot-or-zero, and ld_* never high outside cnt == STEP_CYCLES-2.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer and its step timer.
package seq_pkg;

  typedef enum logic [3:0] {
    HALTED   = 4'd0,
    FETCH_I  = 4'd1,
    INC_I    = 4'd2,
    DECODE   = 4'd3,
    EXEC     = 4'd4,
    FETCH_J1 = 4'd5,
    INC_J1   = 4'd6,
    FETCH_J2 = 4'd7,
    INC_J2   = 4'd8,
    JUMP     = 4'd9
  } seq_state_t;

  localparam logic [7:0] OP_HALT     = 8'hAE;
  localparam logic [1:0] GOTO_PREFIX = 2'b11;
  localparam int         CNT_W       = 4;

  // cond = {s, c, z, nz}; an all-zero condition field is an unconditional jump
  function automatic logic goto_taken(input logic [3:0] cond, input logic fz,
                                      input logic fc, input logic fs);
    logic hit;
    hit = (cond[3] & fs) | (cond[2] & fc) | (cond[1] & fz) | (cond[0] & ~fz);
    return (cond == 4'b0000) | hit;
  endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Handshake and strobe bundle between the sequencer and the datapath around it.
interface instruction_sequencer_if;

  logic       run;
  logic [7:0] inst;
  logic       flag_z;
  logic       flag_c;
  logic       flag_s;
  logic       exec_done;
  logic       sel_pc;
  logic       sel_inc;
  logic       sel_j;
  logic       mem_read;
  logic       ld_inst;
  logic       ld_inc;
  logic       ld_pc;
  logic       ld_j1;
  logic       ld_j2;
  logic       exec_start;
  logic       halted;

  modport slave (
    input  run, inst, flag_z, flag_c, flag_s, exec_done,
    output sel_pc, sel_inc, sel_j, mem_read,
    output ld_inst, ld_inc, ld_pc, ld_j1, ld_j2, exec_start, halted
  );

  modport master (
    output run, inst, flag_z, flag_c, flag_s, exec_done,
    input  sel_pc, sel_inc, sel_j, mem_read,
    input  ld_inst, ld_inc, ld_pc, ld_j1, ld_j2, exec_start, halted
  );

endinterface

// File: rtl/instruction_sequencer_step_timer.sv
// Micro-step counter: counts 0..STEP_CYCLES-1 and flags the load and last cycles.
module step_timer
  import seq_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart,
  output logic [CNT_W-1:0] cnt,
  output logic             load_win,
  output logic             step_last
);

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(STEP_CYCLES - 2);

  logic [CNT_W-1:0] cnt_r;

  // restart holds the counter at zero while the sequencer is not in a timed step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= CNT_W'(0);
    end else if (restart || (cnt_r == LAST_C)) begin
      cnt_r <= CNT_W'(0);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign cnt       = cnt_r;
  assign load_win  = (cnt_r == LOAD_C);
  assign step_last = (cnt_r == LAST_C);

endmodule

// File: rtl/instruction_sequencer.sv
// Micro-step sequencer: fetches the opcode and jump operands, hands plain opcodes to execute.
module instruction_sequencer
  import seq_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  instruction_sequencer_if.slave  bus
);

  seq_state_t       state_r;
  seq_state_t       state_s;
  logic [CNT_W-1:0] cnt_s;
  logic             load_win_s;
  logic             step_last_s;
  logic             restart_s;
  logic             cond_s;
  logic             taken_r;
  logic             jump_taken_s;
  logic             first_s;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (restart_s),
    .cnt       (cnt_s),
    .load_win  (load_win_s),
    .step_last (step_last_s)
  );

  // Jump decision is live on the first JUMP cycle and held afterwards
  always_comb begin
    cond_s       = goto_taken(bus.inst[4:1], bus.flag_z, bus.flag_c, bus.flag_s);
    first_s      = (cnt_s == CNT_W'(0));
    jump_taken_s = first_s ? cond_s : taken_r;
  end

  // Latch the jump decision taken on the first JUMP cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_r <= 1'b0;
    end else if ((state_r == JUMP) && first_s) begin
      taken_r <= cond_s;
    end else begin
      taken_r <= taken_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= HALTED;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and step-timer control
  always_comb begin
    state_s   = state_r;
    restart_s = 1'b1;
    case (state_r)
      HALTED: begin
        if (bus.run) state_s = FETCH_I;
        else         state_s = HALTED;
      end
      FETCH_I: begin
        restart_s = 1'b0;
        state_s   = step_last_s ? INC_I : FETCH_I;
      end
      INC_I: begin
        restart_s = 1'b0;
        state_s   = step_last_s ? DECODE : INC_I;
      end
      DECODE: begin
        if (bus.inst == OP_HALT)                state_s = HALTED;
        else if (bus.inst[7:6] == GOTO_PREFIX) state_s = FETCH_J1;
        else                                    state_s = EXEC;
      end
      EXEC: begin
        state_s = bus.exec_done ? FETCH_I : EXEC;
      end
      FETCH_J1: begin
        restart_s = 1'b0;
        state_s   = step_last_s ? INC_J1 : FETCH_J1;
      end
      INC_J1: begin
        restart_s = 1'b0;
        state_s   = step_last_s ? FETCH_J2 : INC_J1;
      end
      FETCH_J2: begin
        restart_s = 1'b0;
        state_s   = step_last_s ? INC_J2 : FETCH_J2;
      end
      INC_J2: begin
        restart_s = 1'b0;
        state_s   = step_last_s ? JUMP : INC_J2;
      end
      JUMP: begin
        if (!jump_taken_s) begin
          state_s = FETCH_I;
        end else begin
          restart_s = 1'b0;
          state_s   = step_last_s ? FETCH_I : JUMP;
        end
      end
      default: begin
        state_s = HALTED;
      end
    endcase
  end

  // Strobe decode from the registered state and step count
  always_comb begin
    bus.sel_pc     = 1'b0;
    bus.sel_inc    = 1'b0;
    bus.sel_j      = 1'b0;
    bus.mem_read   = 1'b0;
    bus.ld_inst    = 1'b0;
    bus.ld_inc     = 1'b0;
    bus.ld_pc      = 1'b0;
    bus.ld_j1      = 1'b0;
    bus.ld_j2      = 1'b0;
    bus.exec_start = 1'b0;
    bus.halted     = 1'b0;
    case (state_r)
      HALTED: begin
        bus.halted = 1'b1;
      end
      FETCH_I: begin
        bus.sel_pc   = 1'b1;
        bus.mem_read = 1'b1;
        bus.ld_inst  = load_win_s;
        bus.ld_inc   = load_win_s;
      end
      FETCH_J1: begin
        bus.sel_pc   = 1'b1;
        bus.mem_read = 1'b1;
        bus.ld_j1    = load_win_s;
        bus.ld_inc   = load_win_s;
      end
      FETCH_J2: begin
        bus.sel_pc   = 1'b1;
        bus.mem_read = 1'b1;
        bus.ld_j2    = load_win_s;
        bus.ld_inc   = load_win_s;
      end
      INC_I, INC_J1, INC_J2: begin
        bus.sel_inc = 1'b1;
        bus.ld_pc   = load_win_s;
      end
      DECODE: begin
        bus.exec_start = (bus.inst != OP_HALT) && (bus.inst[7:6] != GOTO_PREFIX);
      end
      JUMP: begin
        bus.sel_j = jump_taken_s;
        bus.ld_pc = jump_taken_s & load_win_s;
      end
      default: begin
        bus.halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: a per-cycle schedule built from the step rules drives and checks the DUT.
module tb_instruction_sequencer;

  localparam int SC = 4;

  localparam logic [10:0] V_SEL_PC  = 11'h400;
  localparam logic [10:0] V_SEL_INC = 11'h200;
  localparam logic [10:0] V_SEL_J   = 11'h100;
  localparam logic [10:0] V_MEM     = 11'h080;
  localparam logic [10:0] V_LD_INST = 11'h040;
  localparam logic [10:0] V_LD_INC  = 11'h020;
  localparam logic [10:0] V_LD_PC   = 11'h010;
  localparam logic [10:0] V_LD_J1   = 11'h008;
  localparam logic [10:0] V_LD_J2   = 11'h004;
  localparam logic [10:0] V_XS      = 11'h002;
  localparam logic [10:0] V_HALT    = 11'h001;
  localparam logic [10:0] V_NONE    = 11'h000;

  typedef struct packed {
    logic        run;
    logic        exec_done;
    logic [7:0]  inst;
    logic [2:0]  flags;   // {s, c, z}
    logic [10:0] exp;
  } cyc_t;

  logic  clk = 1'b0;
  logic  reset_n;
  cyc_t  sched[$];
  int    total = 0;
  int    bad = 0;
  int    step = 0;
  logic [10:0] obs;

  always #5 clk = ~clk;

  instruction_sequencer_if bus ();

  instruction_sequencer #(.STEP_CYCLES(SC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign obs = {bus.sel_pc, bus.sel_inc, bus.sel_j, bus.mem_read, bus.ld_inst, bus.ld_inc,
                bus.ld_pc, bus.ld_j1, bus.ld_j2, bus.exec_start, bus.halted};

  always @(negedge clk) begin
    total++;
    assert ($onehot0({bus.sel_pc, bus.sel_inc, bus.sel_j}))
    else begin
      bad++;
      $error("FAIL sel_onehot observed=%b expected=one-hot-or-zero",
             {bus.sel_pc, bus.sel_inc, bus.sel_j});
    end
  end

  task automatic check(input string tag, input logic [10:0] o, input logic [10:0] e);
    total++;
    assert (o === e)
    else begin
      bad++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, o, e);
    end
  endtask

  task automatic push(input logic run, input logic ed, input logic [7:0] inst,
                      input logic [2:0] fl, input logic [10:0] exp);
    cyc_t c;
    c.run = run; c.exec_done = ed; c.inst = inst; c.flags = fl; c.exp = exp;
    sched.push_back(c);
  endtask

  // One timed step: held strobes every cycle, load strobes only on the cycle before last
  task automatic push_step(input logic [7:0] inst, input logic [2:0] first_fl,
                           input logic [10:0] hold, input logic [10:0] loads);
    for (int i = 0; i < SC; i++)
      push(1'($urandom), 1'($urandom), inst, (i == 0) ? first_fl : 3'($urandom),
           (i == SC - 2) ? (hold | loads) : hold);
  endtask

  function automatic logic model_taken(input logic [7:0] inst, input logic [2:0] fl);
    if (inst[4:1] == 4'b0000) return 1'b1;
    return (inst[4] && fl[2]) || (inst[3] && fl[1]) || (inst[2] && fl[0]) || (inst[1] && !fl[0]);
  endfunction

  // Expected cycles for one instruction, starting from its first FETCH_I cycle
  task automatic model_inst(input logic [7:0] inst, input int exec_len, input logic [2:0] jfl,
                            input int halt_wait, input logic resume);
    push_step(inst, 3'($urandom), V_SEL_PC | V_MEM, V_LD_INST | V_LD_INC);
    push_step(inst, 3'($urandom), V_SEL_INC, V_LD_PC);
    if (inst == 8'hAE) begin
      push(1'($urandom), 1'($urandom), inst, 3'($urandom), V_NONE);
      for (int i = 0; i < halt_wait; i++) push(1'b0, 1'($urandom), inst, 3'($urandom), V_HALT);
      if (resume) push(1'b1, 1'($urandom), inst, 3'($urandom), V_HALT);
    end else if (inst[7:6] == 2'b11) begin
      push(1'($urandom), 1'($urandom), inst, 3'($urandom), V_NONE);
      push_step(inst, 3'($urandom), V_SEL_PC | V_MEM, V_LD_J1 | V_LD_INC);
      push_step(inst, 3'($urandom), V_SEL_INC, V_LD_PC);
      push_step(inst, 3'($urandom), V_SEL_PC | V_MEM, V_LD_J2 | V_LD_INC);
      push_step(inst, 3'($urandom), V_SEL_INC, V_LD_PC);
      if (model_taken(inst, jfl)) push_step(inst, jfl, V_SEL_J, V_LD_PC);
      else push(1'($urandom), 1'($urandom), inst, jfl, V_NONE);
    end else begin
      push(1'($urandom), 1'($urandom), inst, 3'($urandom), V_XS);
      for (int i = 1; i <= exec_len; i++)
        push(1'($urandom), (i == exec_len), inst, 3'($urandom), V_NONE);
    end
  endtask

  task automatic play(input string tag);
    cyc_t c;
    while (sched.size() > 0) begin
      c = sched.pop_front();
      bus.run       = c.run;
      bus.exec_done = c.exec_done;
      bus.inst      = c.inst;
      {bus.flag_s, bus.flag_c, bus.flag_z} = c.flags;
      #1;
      check(tag, obs, c.exp);
      step++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] ri;
    reset_n       = 1'b0;
    bus.run       = 1'b0;
    bus.inst      = 8'h00;
    bus.flag_z    = 1'b0;
    bus.flag_c    = 1'b0;
    bus.flag_s    = 1'b0;
    bus.exec_done = 1'b0;
    #2;
    check("reset_async", obs, V_HALT);
    @(posedge clk);
    #1;
    check("reset_held", obs, V_HALT);
    reset_n = 1'b1;

    // Directed program followed by random instructions, ending halted
    push(1'b0, 1'b1, 8'h00, 3'b000, V_HALT);
    push(1'b0, 1'b0, 8'h00, 3'b000, V_HALT);
    push(1'b1, 1'b0, 8'h10, 3'b000, V_HALT);
    model_inst(8'h10, 2, 3'b000, 0, 1'b0);
    model_inst(8'hC0, 1, 3'($urandom), 0, 1'b0);
    model_inst(8'hC4, 1, 3'b110, 0, 1'b0);
    model_inst(8'hC4, 1, 3'b001, 0, 1'b0);
    model_inst(8'hAE, 1, 3'b000, 3, 1'b1);
    for (int n = 0; n < 24; n++) begin
      ri = 8'($urandom);
      if ($urandom_range(0, 1) == 1) ri[7:6] = 2'b11;
      if ($urandom_range(0, 7) == 0) ri = 8'hAE;
      model_inst(ri, $urandom_range(1, 4), 3'($urandom), $urandom_range(0, 3), 1'b1);
    end
    model_inst(8'hAE, 1, 3'b000, 1, 1'b0);
    play("main");

    // Reset in the middle of INC_J1: keep the schedule up to its cnt=0 cycle
    push(1'b1, 1'b0, 8'hC0, 3'b000, V_HALT);
    model_inst(8'hC0, 1, 3'b000, 0, 1'b0);
    while (sched.size() > 3 + 3 * SC) void'(sched.pop_back());
    play("pre_abort");
    check("inc_j1_cnt1", obs, V_SEL_INC);
    reset_n = 1'b0;
    #1;
    check("reset_abort", obs, V_HALT);
    for (int i = 0; i < 2 * SC; i++) begin
      @(posedge clk);
      #1;
      check("reset_quiet", obs, V_HALT);
    end
    reset_n = 1'b1;
    push(1'b0, 1'b0, 8'h10, 3'b000, V_HALT);
    push(1'b1, 1'b0, 8'h10, 3'b000, V_HALT);
    model_inst(8'h10, 2, 3'b000, 0, 1'b0);
    model_inst(8'hAE, 1, 3'b000, 1, 1'b0);
    play("post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
